// File: rtl/decoder_scan_if.sv
// Handshake/bus bundle between a scan controller and its host.
interface decoder_scan_if #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned BLANK_W = 4
);
  logic               start;
  logic               stop;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [BLANK_W-1:0] blank;
  logic [2:0]         A;
  logic               G1;
  logic               G2_n;
  logic               G3_n;
  logic               busy;
  logic               frame_done;

  modport master (
    output start, stop, mask, dwell, blank,
    input  A, G1, G2_n, G3_n, busy, frame_done
  );

  modport slave (
    input  start, stop, mask, dwell, blank,
    output A, G1, G2_n, G3_n, busy, frame_done
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 74LS138-style 3-to-8 decoder: masked channels,
// per-channel dwell, optional blanking gap, frame_done on each wrap.
module decoder_scan_ctrl #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned BLANK_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  decoder_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [BLANK_W-1:0] bcnt_q, bcnt_d;
  logic [2:0]         a_q, a_d;
  logic               fd_q, fd_d;
  logic               g1_q, g2n_q, busy_q;
  logic [DWELL_W-1:0] dwell_eff;
  logic [2:0]         nxt;

  // Lowest set bit of a non-zero mask.
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'(0);
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  // Next set bit above cur, wrapping; returns cur if it is the only one.
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] idx;
    next_ch = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = 3'(cur + 3'(i));
      if (m[idx]) next_ch = idx;
    end
  endfunction

  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign nxt       = next_ch(mask_q, a_q);

  // Next-state, counter and output computation.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    blank_d = blank_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    a_d     = a_q;
    fd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.mask != 8'h00)) begin
          mask_d  = bus.mask;
          dwell_d = dwell_eff;
          blank_d = bus.blank;
          a_d     = lowest(bus.mask);
          if (bus.blank != '0) begin
            state_d = BLANK;
            bcnt_d  = bus.blank;
          end else begin
            state_d = DRIVE;
            dcnt_d  = dwell_eff;
          end
        end
      end
      BLANK: begin
        if (bcnt_q <= BLANK_W'(1)) begin
          state_d = DRIVE;
          bcnt_d  = '0;
          dcnt_d  = dwell_q;
        end else begin
          bcnt_d = bcnt_q - BLANK_W'(1);
        end
      end
      DRIVE: begin
        if (dcnt_q <= DWELL_W'(1)) begin
          a_d  = nxt;
          fd_d = (nxt <= a_q);
          if (blank_q != '0) begin
            state_d = BLANK;
            bcnt_d  = blank_q;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dwell_q;
          end
        end else begin
          dcnt_d = dcnt_q - DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.stop) begin
      state_d = IDLE;
      dcnt_d  = '0;
      bcnt_d  = '0;
      a_d     = 3'(0);
      fd_d    = 1'b0;
    end
  end

  // State, counters and registered outputs; enables follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      blank_q <= '0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      a_q     <= 3'(0);
      fd_q    <= 1'b0;
      g1_q    <= 1'b0;
      g2n_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      dcnt_q  <= dcnt_d;
      bcnt_q  <= bcnt_d;
      a_q     <= a_d;
      fd_q    <= fd_d;
      g1_q    <= (state_d == DRIVE);
      g2n_q   <= (state_d != DRIVE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.A          = a_q;
  assign bus.G1         = g1_q;
  assign bus.G2_n       = g2n_q;
  assign bus.G3_n       = g2n_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;

endmodule
